// File: rtl/schmidl_cox_detector.sv
// -----------------------------------------------------------------------------
// schmidl_cox_detector
//
// Schmidl & Cox timing detector for the OFDM receive chain. For each window
// start d it forms
//   P(d) = sum_{m=0..L-1} conj(r(d+m)) * r(d+m+L)
//   R(d) = sum_{m=0..L-1} |r(d+m+L)|^2
// and reports a crossing when |P|^2 > (threshold * R^2) >> THR_FRAC.
// On a crossing it forwards packet_length samples starting at r(d). It also
// provides a hold-off window after each packet, a pass-through mode and a
// detection counter.
//
// Ports
//   clk            data clock
//   reset          synchronous active-high full reset
//   clear          synchronous flush of all internal state
//   threshold      detection ratio, unsigned fixed point with THR_FRAC fraction bits
//   packet_length  samples per detected packet (0 disables detection)
//   holdoff        samples after a packet during which crossings are ignored
//   mode           0 = gated (packet samples only), 1 = pass (all samples)
//   i_tdata        input sample {I, Q}, each SAMPLE_W signed
//   i_tlast        unused
//   i_tvalid       input valid
//   i_tready       input ready
//   o_tdata        delayed output sample {I, Q}
//   o_tlast        last sample of a detected packet
//   o_tuser        first sample of a detected packet
//   o_tvalid       output valid
//   o_tready       output ready
//   detect_count   detections since reset/clear (wraps)
//   busy           FSM is not searching
//
// Every register advances only on an accepted input sample, so the output
// sample is the input delayed by exactly D = 2L + 3 accepted samples: the
// 2L-sample correlation span plus the three metric registers between the
// product stage and the registered crossing flag.
// -----------------------------------------------------------------------------
module schmidl_cox_detector #(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_L   = 6,
  parameter int THR_FRAC = 16,
  parameter int LEN_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [31:0]           threshold,
  input  logic [LEN_W-1:0]      packet_length,
  input  logic [LEN_W-1:0]      holdoff,
  input  logic                  mode,
  input  logic [2*SAMPLE_W-1:0] i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  output logic [2*SAMPLE_W-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_tuser,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic [31:0]           detect_count,
  output logic                  busy
);

  localparam int L   = 1 << LOG2_L;
  localparam int D   = 2*L + 3;
  localparam int XW  = 2*SAMPLE_W;               // packed {I,Q} sample
  localparam int TW  = 2*SAMPLE_W + 2;           // one product term, per component
  localparam int PW  = TW + LOG2_L;              // P accumulator, per component
  localparam int QW  = 2*SAMPLE_W;               // one energy term
  localparam int RW  = 2*SAMPLE_W + 1 + LOG2_L;  // R accumulator
  localparam int MW  = 2*PW;                     // |P|^2
  localparam int R2W = 2*RW;                     // R^2
  localparam int SW2 = 32 + R2W;                 // threshold * R^2
  localparam int CW  = (MW > SW2) ? MW : SW2;    // common compare width
  localparam int FW  = $clog2(D + 1);

  typedef enum logic [1:0] {SEARCH, PACKET, HOLDOFF} state_t;

  // Re{conj(a) * b} = ar*br + ai*bi
  function automatic logic signed [TW-1:0] conj_mul_re(input logic [XW-1:0] a,
                                                       input logic [XW-1:0] b);
    logic signed [SAMPLE_W-1:0] ar, ai, br, bi;
    logic signed [TW-1:0]       xr, xi, yr, yi;
    ar = a[XW-1:SAMPLE_W];
    ai = a[SAMPLE_W-1:0];
    br = b[XW-1:SAMPLE_W];
    bi = b[SAMPLE_W-1:0];
    xr = TW'(ar);
    xi = TW'(ai);
    yr = TW'(br);
    yi = TW'(bi);
    return xr*yr + xi*yi;
  endfunction

  // Im{conj(a) * b} = ar*bi - ai*br
  function automatic logic signed [TW-1:0] conj_mul_im(input logic [XW-1:0] a,
                                                       input logic [XW-1:0] b);
    logic signed [SAMPLE_W-1:0] ar, ai, br, bi;
    logic signed [TW-1:0]       xr, xi, yr, yi;
    ar = a[XW-1:SAMPLE_W];
    ai = a[SAMPLE_W-1:0];
    br = b[XW-1:SAMPLE_W];
    bi = b[SAMPLE_W-1:0];
    xr = TW'(ar);
    xi = TW'(ai);
    yr = TW'(br);
    yi = TW'(bi);
    return xr*yi - xi*yr;
  endfunction

  // |a|^2 is at most 2^(2*SAMPLE_W-1), so the low QW bits are exact
  function automatic logic [QW-1:0] energy(input logic [XW-1:0] a);
    logic signed [SAMPLE_W-1:0] ar, ai;
    logic signed [TW-1:0]       xr, xi, s;
    ar = a[XW-1:SAMPLE_W];
    ai = a[SAMPLE_W-1:0];
    xr = TW'(ar);
    xi = TW'(ai);
    s  = xr*xr + xi*xi;
    return s[QW-1:0];
  endfunction

  // Sum of squares may set the top bit, hence the unsigned result
  function automatic logic [MW-1:0] mag2(input logic signed [PW-1:0] re,
                                         input logic signed [PW-1:0] im);
    logic signed [MW-1:0] a, b;
    a = MW'(re);
    b = MW'(im);
    return $unsigned(a*a + b*b);
  endfunction

  function automatic logic [R2W-1:0] rsq(input logic [RW-1:0] r);
    logic [R2W-1:0] x;
    x = R2W'(r);
    return x*x;
  endfunction

  // Strict compare against the floored scaled energy; all-zero input never crosses
  function automatic logic crossing(input logic [MW-1:0]  pm,
                                    input logic [R2W-1:0] r2,
                                    input logic [31:0]    thr);
    logic [SW2-1:0] prod;
    logic [CW-1:0]  lhs, rhs;
    prod = SW2'(thr) * SW2'(r2);
    rhs  = CW'(prod >> THR_FRAC);
    lhs  = CW'(pm);
    return lhs > rhs;
  endfunction

  logic                 adv;
  logic [XW-1:0]        dl [D];  // dl[k] = r(n-1-k) where r(n) is the sample being accepted
  logic signed [TW-1:0] pn_re_p0, pn_im_p0, po_re_p0, po_im_p0;
  logic [QW-1:0]        rn_p0, ro_p0;
  logic signed [PW-1:0] p_re_p1, p_im_p1;
  logic [RW-1:0]        r_p1;
  logic [MW-1:0]        pmag_p2;
  logic [R2W-1:0]       r2_p2;
  logic                 cross_p3;
  logic [FW-1:0]        fill;

  state_t               state;
  logic [LEN_W-1:0]     cnt, len_lat, hold_lat;
  logic                 mode_lat;

  logic [XW-1:0]        tap;
  logic                 tap_real, det, last_smp, pass_eff, emit;
  logic                 unused_tlast;

  assign unused_tlast = i_tlast;
  assign i_tready     = !o_tvalid || o_tready;
  assign adv          = i_tvalid && i_tready;
  assign busy         = (state != SEARCH);

  // Running sums are updated as sum + new - old in fixed width; the wrap is
  // harmless because the true sum always fits and the delay line starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < D; k++) dl[k] <= '0;
      pn_re_p0 <= '0;
      pn_im_p0 <= '0;
      po_re_p0 <= '0;
      po_im_p0 <= '0;
      rn_p0    <= '0;
      ro_p0    <= '0;
      p_re_p1  <= '0;
      p_im_p1  <= '0;
      r_p1     <= '0;
      pmag_p2  <= '0;
      r2_p2    <= '0;
      cross_p3 <= 1'b0;
    end else if (adv) begin
      dl[0] <= i_tdata;
      for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
      // p0: entering term uses r(n-L), r(n); leaving term uses r(n-2L), r(n-L)
      pn_re_p0 <= conj_mul_re(dl[L-1], i_tdata);
      pn_im_p0 <= conj_mul_im(dl[L-1], i_tdata);
      po_re_p0 <= conj_mul_re(dl[2*L-1], dl[L-1]);
      po_im_p0 <= conj_mul_im(dl[2*L-1], dl[L-1]);
      rn_p0    <= energy(i_tdata);
      ro_p0    <= energy(dl[L-1]);
      // p1: running correlation and energy
      p_re_p1  <= p_re_p1 + PW'(pn_re_p0) - PW'(po_re_p0);
      p_im_p1  <= p_im_p1 + PW'(pn_im_p0) - PW'(po_im_p0);
      r_p1     <= r_p1 + RW'(rn_p0) - RW'(ro_p0);
      // p2: squared magnitudes
      pmag_p2  <= mag2(p_re_p1, p_im_p1);
      r2_p2    <= rsq(r_p1);
      // p3: threshold decision for window start d = n - D
      cross_p3 <= crossing(pmag_p2, r2_p2, threshold);
    end
  end

  // The tapped sample r(n-D) is the window start that cross_p3 refers to.
  // tap_real masks both warm-up detection and pass-mode output of the
  // zero-filled delay line.
  always_comb begin
    tap      = dl[D-1];
    tap_real = (fill == FW'(D));
    det      = (state == SEARCH) && tap_real && cross_p3 && (packet_length != '0);
    last_smp = 1'b0;
    if (det)
      last_smp = (packet_length == LEN_W'(1));
    else if (state == PACKET)
      last_smp = (cnt == len_lat - LEN_W'(1));
    pass_eff = (state == SEARCH) ? mode : mode_lat;
    emit     = tap_real && (det || (state == PACKET) || pass_eff);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= SEARCH;
      cnt          <= '0;
      len_lat      <= '0;
      hold_lat     <= '0;
      mode_lat     <= 1'b0;
      detect_count <= '0;
      fill         <= '0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_tuser      <= 1'b0;
    end else if (adv) begin
      o_tvalid <= emit;
      if (emit) begin
        o_tuser <= det;
        o_tlast <= last_smp;
      end
      if (fill != FW'(D)) fill <= fill + FW'(1);
      unique case (state)
        SEARCH: begin
          mode_lat <= mode;
          if (det) begin
            detect_count <= detect_count + 32'd1;
            len_lat      <= packet_length;
            hold_lat     <= holdoff;
            if (last_smp) begin
              state <= (holdoff != '0) ? HOLDOFF : SEARCH;
              cnt   <= '0;
            end else begin
              state <= PACKET;
              cnt   <= LEN_W'(1);
            end
          end
        end
        PACKET: begin
          if (last_smp) begin
            state <= (hold_lat != '0) ? HOLDOFF : SEARCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == hold_lat - LEN_W'(1)) begin
            state <= SEARCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Output payload carries no reset; it is qualified by o_tvalid
  always_ff @(posedge clk) begin
    if (adv && emit) o_tdata <= tap;
  end

endmodule

// File: tb/tb_schmidl_cox_detector.sv
// -----------------------------------------------------------------------------
// tb_schmidl_cox_detector
//
// Scoreboard bench for schmidl_cox_detector with L = 16. The stimulus task
// pushes the expected output for each input sample as it is issued; a monitor
// pops and compares on every output handshake, including the accept index at
// which the sample must appear (input index + D).
// -----------------------------------------------------------------------------
module tb_schmidl_cox_detector;

  // L = 16: two half-windows plus the three metric registers
  localparam int D = 35;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] threshold;
  logic [15:0] packet_length, holdoff;
  logic        mode;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tuser, o_tvalid, o_tready;
  logic [31:0] detect_count;
  logic        busy;

  schmidl_cox_detector #(
    .SAMPLE_W(16),
    .LOG2_L  (4),
    .THR_FRAC(16),
    .LEN_W   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .threshold    (threshold),
    .packet_length(packet_length),
    .holdoff      (holdoff),
    .mode         (mode),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tuser      (o_tuser),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .detect_count (detect_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        tuser;
    logic        tlast;
    int          idx;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          acc_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] pre [32];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  // Output ready driver
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: one comparison per output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && o_tvalid && o_tready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL out_unexpected got data=%h user=%b last=%b at_accept=%0d, expected no output",
                   o_tdata, o_tuser, o_tlast, acc_cnt);
        end else begin
          e = q.pop_front();
          if (o_tdata === e.data && o_tuser === e.tuser && o_tlast === e.tlast &&
              acc_cnt == e.idx + D + 1)
            passed++;
          else
            $display("FAIL out[%0d] got data=%h user=%b last=%b at_accept=%0d, expected data=%h user=%b last=%b at_accept=%0d",
                     e.idx, o_tdata, o_tuser, o_tlast, acc_cnt, e.data, e.tuser, e.tlast, e.idx + D + 1);
        end
      end
    end
  end

  task automatic do_reset();
    rand_ready = 1'b0;
    i_tvalid   = 1'b0;
    clear      = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    acc_cnt = 0;
    reset   = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    bit acc;
    i_tdata  = x;
    i_tvalid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        return;
      end
    end
    $display("FAIL send_timeout got=no_accept expected=accept within 1000 cycles");
    $fatal(1, "input stalled");
  endtask

  function automatic logic [31:0] sample_at(input int j, input int pa, input int pb);
    if (pa >= 0 && j >= pa && j < pa + 32) return pre[j - pa];
    if (pb >= 0 && j >= pb && j < pb + 32) return pre[j - pb];
    return 32'h0;
  endfunction

  // n samples with preambles at pa/pb (-1 = none); packets expected at ka/kb.
  // cut >= 0 clears the detector right after packet sample cut-1 has been loaded.
  task automatic run_stream(input int n, input int pa, input int pb, input int ka, input int kb,
                            input int len, input bit pass, input int cut, input bit gaps);
    logic [31:0] x;
    bit          in_a, in_b;
    exp_t        e;
    for (int j = 0; j < n; j++) begin
      x    = sample_at(j, pa, pb);
      in_a = (ka >= 0) && (j >= ka) && (j < ka + len);
      in_b = (kb >= 0) && (j >= kb) && (j < kb + len);
      if ((pass ? (j < n - D) : (in_a || in_b)) && (cut < 0 || j < cut)) begin
        e.data  = x;
        e.tuser = (j == ka) || (j == kb);
        e.tlast = (ka >= 0 && j == ka + len - 1) || (kb >= 0 && j == kb + len - 1);
        e.idx   = j;
        q.push_back(e);
      end
      send(x);
      if (gaps && $urandom_range(0, 1) == 1) begin
        i_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      if (cut >= 0 && j == cut + D - 1) begin
        i_tvalid = 1'b0;
        check("busy_before_clear", {63'd0, busy}, 64'd1);
        check("count_before_clear", {32'd0, detect_count}, 64'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("busy_after_clear", {63'd0, busy}, 64'd0);
        check("count_after_clear", {32'd0, detect_count}, 64'd0);
        check("valid_after_clear", {63'd0, o_tvalid}, 64'd0);
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic finish_test(input string name, input int exp_det, input bit exp_busy);
    for (int c = 0; c < 3000 && q.size() != 0; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check({name, "_drain"}, 64'(q.size()), 64'd0);
    check({name, "_detect_count"}, {32'd0, detect_count}, 64'(exp_det));
    check({name, "_busy"}, {63'd0, busy}, {63'd0, exp_busy});
  endtask

  task automatic cfg(input logic [31:0] thr, input logic [15:0] len, input logic [15:0] ho,
                     input logic md);
    threshold     = thr;
    packet_length = len;
    holdoff       = ho;
    mode          = md;
  endtask

  initial begin
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    clear    = 1'b0;
    reset    = 1'b1;
    // The metric ratio is (15/16)^2 = 0.879 one sample before the preamble and
    // exactly 1.0 at its start, so 0xF000 (0.9375) places o_tuser on preamble sample 0.
    cfg(32'h0000F000, 16'd100, 16'd0, 1'b0);
    for (int m = 0; m < 16; m++) begin
      pre[m][31:16] = ($urandom_range(0, 1) == 1) ? 16'h4000 : 16'hC000;
      pre[m][15:0]  = ($urandom_range(0, 1) == 1) ? 16'h4000 : 16'hC000;
      pre[m + 16]   = pre[m];
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    check("rst_o_tuser", {63'd0, o_tuser}, 64'd0);
    check("rst_o_tlast", {63'd0, o_tlast}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_detect_count", {32'd0, detect_count}, 64'd0);
    do_reset();
    @(posedge clk);
    #1;
    check("rst_i_tready", {63'd0, i_tready}, 64'd1);

    // 1: single preamble, gated
    run_stream(400, 200, -1, 200, -1, 100, 1'b0, -1, 1'b0);
    finish_test("t1", 1, 1'b0);

    // 2: zero input, zero threshold
    do_reset();
    cfg(32'h0, 16'd100, 16'd0, 1'b0);
    run_stream(1000, -1, -1, -1, -1, 100, 1'b0, -1, 1'b0);
    finish_test("t2", 0, 1'b0);

    // 3a: second preamble falls inside the hold-off window
    do_reset();
    cfg(32'h0000F000, 16'd100, 16'd200, 1'b0);
    run_stream(600, 200, 350, 200, -1, 100, 1'b0, -1, 1'b0);
    finish_test("t3a", 1, 1'b0);

    // 3b: no hold-off, both preambles detected
    do_reset();
    cfg(32'h0000F000, 16'd100, 16'd0, 1'b0);
    run_stream(600, 200, 350, 200, 350, 100, 1'b0, -1, 1'b0);
    finish_test("t3b", 2, 1'b0);

    // 4: test 1 under random backpressure and input gaps
    do_reset();
    cfg(32'h0000F000, 16'd100, 16'd0, 1'b0);
    rand_ready = 1'b1;
    run_stream(400, 200, -1, 200, -1, 100, 1'b0, -1, 1'b1);
    finish_test("t4", 1, 1'b0);

    // 5: pass-through mode
    do_reset();
    cfg(32'h0000F000, 16'd100, 16'd0, 1'b1);
    run_stream(400, 200, -1, 200, -1, 100, 1'b1, -1, 1'b0);
    finish_test("t5", 1, 1'b0);

    // 6: clear after 40 packet samples
    do_reset();
    cfg(32'h0000F000, 16'd100, 16'd0, 1'b0);
    run_stream(400, 200, -1, 200, -1, 100, 1'b0, 240, 1'b0);
    finish_test("t6", 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
